// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU normalize/round stage: field widths,
// FSM state encoding, flag bit positions and IEEE-754 special encodings.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit positions inside o_flags = {overflow, underflow, inexact, zero}
    localparam int OVF = 3;
    localparam int UNF = 2;
    localparam int INX = 1;
    localparam int ZRO = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

endpackage

// File: rtl/fpu_round.sv
// Combinational round-to-nearest-even incrementer.
// Input layout: [FRAC_W+2] hidden, [FRAC_W+1:2] fraction, [1] guard, [0] round.
// Returns the rounded {hidden, fraction}, the carry out of the hidden bit
// and the inexact indication (any discarded bit set).
module fpu_round #(
    parameter int FRAC_W = fpu_pkg::FRAC_W
) (
    input  logic [FRAC_W+2:0] i_mant,
    input  logic              i_sticky,
    output logic [FRAC_W:0]   o_mant,
    output logic              o_carry,
    output logic              o_inexact
);
    import fpu_pkg::*;

    logic w_lsb;
    logic w_guard;
    logic w_round;
    logic w_inc;

    assign w_lsb   = i_mant[2];
    assign w_guard = i_mant[1];
    assign w_round = i_mant[0];

    // Round up above half, and on an exact tie only when the kept lsb is odd
    assign w_inc     = w_guard & (w_round | i_sticky | w_lsb);
    assign o_inexact = w_guard | w_round | i_sticky;

    assign {o_carry, o_mant} = {1'b0, i_mant[FRAC_W+2:2]} + {{(FRAC_W+1){1'b0}}, w_inc};

endmodule

// File: rtl/fpu_normalize.sv
// Post-add normalize/round stage: captures the adder's raw result,
// normalizes one bit per cycle, rounds to nearest-even and packs an
// IEEE-754 single with {overflow, underflow, inexact, zero} flags.
// Build option: define FPU_DENORM_EN to produce denormal results; when it
// is undefined, tiny results flush to signed zero with underflow set.
module fpu_normalize #(
    parameter int EXP_W         = fpu_pkg::EXP_W,
    parameter int FRAC_W        = fpu_pkg::FRAC_W,
    parameter int BIAS          = fpu_pkg::BIAS,
    parameter bit ZERO_SIGN_POS = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic                    i_sign,
    input  logic [EXP_W+1:0]        i_exp,
    input  logic [FRAC_W+3:0]       i_mant,
    input  logic                    i_sticky,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [EXP_W+FRAC_W:0]   o_c,
    output logic [3:0]              o_flags
);
    import fpu_pkg::*;

    localparam int M_W = FRAC_W + 4;
    localparam int E_W = EXP_W + 2;
    localparam int C_W = 1 + EXP_W + FRAC_W;

    localparam logic signed [E_W-1:0] L_EXP_ONE = E_W'(1);
    localparam logic signed [E_W-1:0] L_EXP_OVF = E_W'(2 * BIAS + 1);

    state_t                  r_state;
    logic                    r_sign;
    logic signed [E_W-1:0]   r_exp;
    logic [M_W-1:0]          r_mant;
    logic                    r_sticky;
    logic [C_W-1:0]          r_c;
    logic [3:0]              r_flags;
    logic                    r_valid;

    state_t                  w_state_next;
    logic                    w_sign_next;
    logic signed [E_W-1:0]   w_exp_next;
    logic [M_W-1:0]          w_mant_next;
    logic                    w_sticky_next;
    logic [C_W-1:0]          w_c_next;
    logic [3:0]              w_flags_next;
    logic                    w_valid_next;

    logic [FRAC_W:0]         w_rnd_mant;
    logic                    w_rnd_carry;
    logic                    w_rnd_inexact;
    logic signed [E_W-1:0]   w_exp_rnd;
    logic                    w_hidden;
    logic [FRAC_W-1:0]       w_frac;
    logic [EXP_W-1:0]        w_exp_field;
    logic                    w_zero_sign;

    fpu_round #(
        .FRAC_W (FRAC_W)
    ) u_round (
        .i_mant    (r_mant[M_W-2:0]),
        .i_sticky  (r_sticky),
        .o_mant    (w_rnd_mant),
        .o_carry   (w_rnd_carry),
        .o_inexact (w_rnd_inexact)
    );

    // A rounding carry renormalizes to 1.000..: exponent up, fraction cleared
    assign w_exp_rnd   = r_exp + {{(E_W-1){1'b0}}, w_rnd_carry};
    assign w_hidden    = w_rnd_carry | w_rnd_mant[FRAC_W];
    assign w_frac      = w_rnd_carry ? {FRAC_W{1'b0}} : w_rnd_mant[FRAC_W-1:0];
    assign w_exp_field = w_hidden ? w_exp_rnd[EXP_W-1:0] : {EXP_W{1'b0}};
    assign w_zero_sign = ZERO_SIGN_POS ? 1'b0 : r_sign;

    // Next-state and datapath updates; one normalization step per NORM cycle
    always_comb begin
        w_state_next  = r_state;
        w_sign_next   = r_sign;
        w_exp_next    = r_exp;
        w_mant_next   = r_mant;
        w_sticky_next = r_sticky;
        w_c_next      = r_c;
        w_flags_next  = r_flags;
        w_valid_next  = r_valid;

        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_sign_next   = i_sign;
                    w_exp_next    = i_exp;
                    w_mant_next   = i_mant;
                    w_sticky_next = i_sticky;
                    w_state_next  = NORM;
                end
            end

            NORM: begin
                if (r_mant == '0 && !r_sticky) begin
                    // Exact cancellation
                    w_c_next          = {w_zero_sign, {(C_W-1){1'b0}}};
                    w_flags_next      = 4'b0000;
                    w_flags_next[ZRO] = 1'b1;
                    w_valid_next      = 1'b1;
                    w_state_next      = DONE;
                end else if (r_mant[M_W-1]) begin
                    // Carry out of the add: one right shift is always enough
                    w_mant_next   = {1'b0, r_mant[M_W-1:1]};
                    w_sticky_next = r_sticky | r_mant[0];
                    w_exp_next    = r_exp + L_EXP_ONE;
                    w_state_next  = ROUND;
                end
`ifdef FPU_DENORM_EN
                else if (r_exp < L_EXP_ONE) begin
                    // Below the normal range: denormalize toward exp==1
                    w_mant_next   = {1'b0, r_mant[M_W-1:1]};
                    w_sticky_next = r_sticky | r_mant[0];
                    w_exp_next    = r_exp + L_EXP_ONE;
                end else if (!r_mant[M_W-2] && r_exp > L_EXP_ONE) begin
                    w_mant_next = {r_mant[M_W-2:0], 1'b0};
                    w_exp_next  = r_exp - L_EXP_ONE;
                end else begin
                    w_state_next = ROUND;
                end
`else
                else if (r_exp < L_EXP_ONE || (r_exp == L_EXP_ONE && !r_mant[M_W-2])) begin
                    // Result too small for a normal: flush to signed zero
                    w_c_next          = {r_sign, {(C_W-1){1'b0}}};
                    w_flags_next      = 4'b0000;
                    w_flags_next[UNF] = 1'b1;
                    w_flags_next[ZRO] = 1'b1;
                    w_valid_next      = 1'b1;
                    w_state_next      = DONE;
                end else if (!r_mant[M_W-2]) begin
                    // exp > 1 is guaranteed here by the branch above
                    w_mant_next = {r_mant[M_W-2:0], 1'b0};
                    w_exp_next  = r_exp - L_EXP_ONE;
                end else begin
                    w_state_next = ROUND;
                end
`endif
            end

            ROUND: begin
                w_flags_next = 4'b0000;
                if (w_exp_rnd >= L_EXP_OVF) begin
                    w_c_next          = {r_sign, PINF[C_W-2:0]};
                    w_flags_next[OVF] = 1'b1;
                    w_flags_next[INX] = 1'b1;
                end else begin
                    w_c_next          = {r_sign, w_exp_field, w_frac};
                    w_flags_next[INX] = w_rnd_inexact;
`ifdef FPU_DENORM_EN
                    w_flags_next[UNF] = !w_hidden && w_rnd_inexact;
                    w_flags_next[ZRO] = !w_hidden && (w_frac == '0);
`endif
                end
                w_valid_next = 1'b1;
                w_state_next = DONE;
            end

            DONE: begin
                if (i_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_mant   <= '0;
            r_sticky <= 1'b0;
            r_c      <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sign   <= w_sign_next;
            r_exp    <= w_exp_next;
            r_mant   <= w_mant_next;
            r_sticky <= w_sticky_next;
            r_c      <= w_c_next;
            r_flags  <= w_flags_next;
            r_valid  <= w_valid_next;
        end
    end

    assign o_ready = (r_state == IDLE);
    assign o_valid = r_valid;
    assign o_c     = r_c;
    assign o_flags = r_flags;

endmodule

// File: tb/tb_fpu_normalize.sv
// Bench for fpu_normalize: directed vectors with literal expectations plus
// an arithmetic reference model checked on every cycle a result is valid.
module tb_fpu_normalize;

    localparam bit ZSP = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [9:0]  i_exp;
    logic [26:0] i_mant;
    logic        i_sticky;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_c;
    logic [3:0]  o_flags;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    fpu_normalize #(
        .ZERO_SIGN_POS (ZSP)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_sign    (i_sign),
        .i_exp     (i_exp),
        .i_mant    (i_mant),
        .i_sticky  (i_sticky),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_c       (o_c),
        .o_flags   (o_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Reference: treat the input as a number, normalize it arithmetically,
    // round with RNE by comparing the discarded part against one half.
    function automatic exp_t model(input logic s, input logic [9:0] ei,
                                   input logic [26:0] mi, input logic st);
        exp_t r;
        int   e, m, k, q, rem;
        bit   sk, inc, inx;
        e = int'($signed(ei));
        m = int'(mi);
        sk = st;
        k = 0;
        r.f = 4'b0000;
        if (m == 0 && !sk) begin
            r.c = {(ZSP != 0) ? 1'b0 : s, 31'b0};
            r.f = 4'b0001;
            r.lat = 1;
            return r;
        end
        if (m >= (1 << 26)) begin
            sk = sk | (m % 2 == 1);
            m = m / 2;
            e = e + 1;
        end else begin
`ifdef FPU_DENORM_EN
            while (e < 1) begin
                sk = sk | (m % 2 == 1);
                m = m / 2;
                e++;
                k++;
            end
`endif
            while (m < (1 << 25) && e > 1) begin
                m = m * 2;
                e--;
                k++;
            end
`ifndef FPU_DENORM_EN
            if (e < 1 || m < (1 << 25)) begin
                r.c = {s, 31'b0};
                r.f = 4'b0101;
                r.lat = 1 + k;
                return r;
            end
`endif
        end
        q   = m / 4;
        rem = m % 4;
        inx = (rem != 0) || sk;
        inc = (rem == 3) || (rem == 2 && (sk || (q % 2 == 1)));
        q   = q + int'(inc);
        if (q == (1 << 24)) begin
            q = 1 << 23;
            e++;
        end
        r.lat = 2 + k;
        if (e >= 255) begin
            r.c = {s, 8'hFF, 23'h0};
            r.f = 4'b1010;
        end else begin
            r.c = {s, (q >= (1 << 23)) ? e[7:0] : 8'h00, q[22:0]};
            r.f[1] = inx;
`ifdef FPU_DENORM_EN
            r.f[2] = (q < (1 << 23)) && inx;
            r.f[0] = (q == 0);
`endif
        end
        return r;
    endfunction

    // Compare process: snapshot the model at each accept, then check
    // latency, result and flags on every cycle o_valid is high.
    exp_t pend;
    bit   have = 1'b0;
    bit   seen = 1'b0;
    int   cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            have = 1'b0;
            seen = 1'b0;
        end else begin
            if (have) begin
                cnt++;
                chk("busy_ready", 32'(o_ready), 32'd0);
                if (o_valid) begin
                    if (!seen) begin
                        chk("model_latency", cnt, pend.lat);
                        seen = 1'b1;
                    end
                    chk("model_c", o_c, pend.c);
                    chk("model_flags", 32'(o_flags), 32'(pend.f));
                    if (i_ready) begin
                        have = 1'b0;
                        seen = 1'b0;
                    end
                end
            end else begin
                chk("spurious_valid", 32'(o_valid), 32'd0);
            end
            if (i_valid && o_ready) begin
                pend = model(i_sign, i_exp, i_mant, i_sticky);
                have = 1'b1;
                seen = 1'b0;
                cnt  = -1;
            end
        end
    end

    // Drive one operation with literal expectations; hold i_ready low for
    // 'hold' cycles after o_valid rises. Called at posedge+1.
    task automatic run_vec(input string nm, input logic s, input logic [9:0] e,
                           input logic [26:0] m, input logic st,
                           input logic [31:0] xc, input logic [3:0] xf,
                           input int xlat, input int hold);
        int   lat;
        exp_t mr;
        mr = model(s, e, m, st);
        chk({nm, "_model_c"}, mr.c, xc);
        chk({nm, "_model_lat"}, mr.lat, xlat);
        chk({nm, "_ready"}, 32'(o_ready), 32'd1);
        i_sign   = s;
        i_exp    = e;
        i_mant   = m;
        i_sticky = st;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, xlat);
        chk({nm, "_c"}, o_c, xc);
        chk({nm, "_flags"}, 32'(o_flags), 32'(xf));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 32'(o_valid), 32'd1);
            chk({nm, "_hold_c"}, o_c, xc);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk({nm, "_after_valid"}, 32'(o_valid), 32'd0);
        chk({nm, "_after_ready"}, 32'(o_ready), 32'd1);
        $display("vector %s: c=%h flags=%b latency=%0d", nm, o_c, o_flags, lat);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_sign   = 1'b0;
        i_exp    = '0;
        i_mant   = '0;
        i_sticky = 1'b0;
        i_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_c", o_c, 32'd0);
        chk("reset_flags", 32'(o_flags), 32'd0);
        chk("reset_ready", 32'(o_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_vec("one_plus_one", 1'b0, 10'd127, 27'h4000000, 1'b0, 32'h40000000, 4'b0000, 2, 0);
        run_vec("two_lshift",   1'b0, 10'd127, 27'h0800000, 1'b0, 32'h3E800000, 4'b0000, 4, 5);
        run_vec("exact_zero",   1'b1, 10'd127, 27'h0000000, 1'b0, 32'h00000000, 4'b0001, 1, 0);
        run_vec("tie_even_dn",  1'b0, 10'd127, 27'h2000002, 1'b0, 32'h3F800000, 4'b0010, 2, 0);
        run_vec("tie_odd_up",   1'b0, 10'd127, 27'h2000006, 1'b0, 32'h3F800002, 4'b0010, 2, 0);
        run_vec("above_half",   1'b0, 10'd127, 27'h2000003, 1'b0, 32'h3F800001, 4'b0010, 2, 0);
        run_vec("sticky_tie",   1'b0, 10'd127, 27'h2000002, 1'b1, 32'h3F800001, 4'b0010, 2, 0);
        run_vec("carry_sticky", 1'b0, 10'd127, 27'h4000001, 1'b0, 32'h40000000, 4'b0010, 2, 0);
        run_vec("round_carry",  1'b1, 10'd127, 27'h3FFFFFE, 1'b0, 32'hC0000000, 4'b0010, 2, 0);
        run_vec("overflow",     1'b0, 10'd254, 27'h4000000, 1'b0, 32'h7F800000, 4'b1010, 2, 0);
        run_vec("rnd_overflow", 1'b0, 10'd254, 27'h3FFFFFE, 1'b0, 32'h7F800000, 4'b1010, 2, 0);
`ifdef FPU_DENORM_EN
        run_vec("tiny_exp1",    1'b0, 10'd1,   27'h1000000, 1'b0, 32'h00400000, 4'b0000, 2, 0);
        run_vec("lshift_tiny",  1'b0, 10'd2,   27'h0800000, 1'b0, 32'h00400000, 4'b0000, 3, 0);
        run_vec("exp_zero",     1'b1, 10'd0,   27'h2000000, 1'b0, 32'h80400000, 4'b0000, 3, 0);
`else
        run_vec("tiny_exp1",    1'b0, 10'd1,   27'h1000000, 1'b0, 32'h00000000, 4'b0101, 1, 0);
        run_vec("lshift_tiny",  1'b0, 10'd2,   27'h0800000, 1'b0, 32'h00000000, 4'b0101, 2, 0);
        run_vec("exp_zero",     1'b1, 10'd0,   27'h2000000, 1'b0, 32'h80000000, 4'b0101, 1, 0);
`endif
        run_vec("lshift_limit", 1'b0, 10'd3,   27'h0800000, 1'b0, 32'h00800000, 4'b0000, 4, 0);

        // Reset while the stage is mid-normalization
        i_sign   = 1'b0;
        i_exp    = 10'd127;
        i_mant   = 27'h0800000;
        i_sticky = 1'b0;
        i_valid  = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk("midnorm_busy", 32'(o_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midnorm_rst_valid", 32'(o_valid), 32'd0);
        chk("midnorm_rst_c", o_c, 32'd0);
        chk("midnorm_rst_ready", 32'(o_ready), 32'd1);
        $display("vector midnorm_reset: c=%h valid=%b ready=%b", o_c, o_valid, o_ready);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_vec("post_reset",   1'b0, 10'd127, 27'h4000000, 1'b0, 32'h40000000, 4'b0000, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
